round_key_store: RTL and testbench
==================================

ROUND_KEY_STORE -- requirements
Module: round_key_store

Interface
REQ-001 SHALL have parameter NUM_RK, default 15, number of AES-256 round keys held (indices 0..14).
REQ-002 SHALL have parameter RK_W, default 128, round key width in bits.
REQ-003 SHALL have clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ks_load  input  1  key-schedule producer strobe; ks_out valid for index ks_round.
REQ-006 SHALL have ks_round  input  4  index of round key presented on ks_out.
REQ-007 SHALL have ks_out  input  RK_W  round key from the key-schedule producer.
REQ-008 SHALL have rk_start  input  1  one-cycle request to begin a key delivery sequence.
REQ-009 SHALL have rk_dir  input  1  sequence order, sampled with rk_start: 0 forward (0->14, encrypt), 1 reverse (14->0, decrypt).
REQ-010 SHALL have rk_req  input  1  consumer ready; key transfers when rk_valid && rk_req.
REQ-011 SHALL have rk_valid  output  1  rk_key/rk_idx hold a deliverable key.
REQ-012 SHALL have rk_key  output  RK_W  delivered round key.
REQ-013 SHALL have rk_idx  output  4  index of rk_key.
REQ-014 SHALL have rk_last  output  1  rk_key is final key of the sequence (idx 14 forward, 0 reverse).
REQ-015 SHALL have keys_ready  output  1  all NUM_RK keys captured, store usable.

Function
REQ-016 States SHALL be IDLE, LOADING, READY, SERVE.
REQ-017 IDLE->LOADING, READY->LOADING, SERVE->LOADING SHALL occur on ks_load rising edge (registered previous value 0, current 1); the 15-bit valid bitmap clears in the same cycle.
REQ-018 Every cycle with ks_load=1 and ks_round<NUM_RK SHALL write ks_out to entry ks_round and set its bitmap bit; ks_round>=15 SHALL be ignored.
REQ-019 LOADING->READY SHALL occur when bitmap is all ones and ks_load=0; keys_ready=1 exactly in READY and SERVE.
REQ-020 Producer dropping ks_load with bitmap incomplete SHALL leave state LOADING, keys_ready=0 until a new load completes.
REQ-021 rk_start in READY SHALL latch rk_dir, enter SERVE, and assert rk_valid on the next cycle with rk_key=entry 0 (forward) or entry 14 (reverse).
REQ-022 rk_start in IDLE, LOADING or SERVE SHALL be ignored.
REQ-023 rk_key, rk_idx, rk_last SHALL be registered and held stable while rk_valid=1 and rk_req=0.
REQ-024 On transfer of a non-last key, next cycle SHALL present idx+1 (forward) or idx-1 (reverse) with rk_valid=1, giving one key per cycle when rk_req held high.
REQ-025 On transfer of the last key, SHALL return to READY with rk_valid=0, rk_last=0 next cycle; store contents retained for further sequences.
REQ-026 ks_load rising edge coincident with rk_start or a transfer SHALL win: sequence aborted, rk_valid=0 next cycle, state LOADING.
REQ-027 rk_idx SHALL never leave 0..14; no wrap-around.

Reset
REQ-028 n_rst low SHALL force state IDLE, bitmap 0, ks_load history 0, rk_valid=0, rk_key=0, rk_idx=0, rk_last=0, keys_ready=0, direction 0, mid-load or mid-sequence alike.
REQ-029 Key storage entries SHALL not require reset; they are unreadable until rewritten.

Structure
REQ-030 Shared package aes_pkg SHALL hold NUM_RK, RK_W and the state enum rks_state_t.
REQ-031 Storage SHALL be sub-module rk_regfile: 15xRK_W, one synchronous write port, one combinational read port indexed by next rk_idx.

Verification
REQ-032 Load keys k_i=128'h{i repeated} for i=0..14 on consecutive ks_load cycles -> keys_ready=1 the cycle after ks_load falls.
REQ-033 rk_start rk_dir=0, rk_req=1 constant -> rk_valid from next cycle, rk_idx 0..14 on 15 consecutive cycles, rk_last only at idx 14, then rk_valid=0.
REQ-034 rk_start rk_dir=1 with rk_req toggling 1,0,1,0 -> idx 14,13,... advances only on rk_req=1 cycles, key stable during stalls, rk_last at idx 0.
REQ-035 ks_load rises during SERVE at idx 5 -> rk_valid=0 next cycle, keys_ready=0, rk_start ignored until 15 new keys loaded.
REQ-036 Load only rounds 0..9 then drop ks_load -> keys_ready stays 0, rk_start produces no rk_valid.
REQ-037 Assert n_rst mid-sequence at idx 7 -> all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared round-key store parameters and state type
package aes_pkg;

    localparam int NUM_RK   = 15;
    localparam int RK_W     = 128;
    localparam int RK_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2,
        SERVE   = 2'd3
    } rks_state_t;

endpackage

// File: rtl/rk_regfile.sv
// rtl/rk_regfile.sv - round key storage, one sync write port, one comb read port
module rk_regfile #(
    parameter int NUM_RK = aes_pkg::NUM_RK,
    parameter int RK_W   = aes_pkg::RK_W
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [aes_pkg::RK_IDX_W-1:0] wr_idx,
    input  logic [RK_W-1:0]             wr_data,
    input  logic [aes_pkg::RK_IDX_W-1:0] rd_idx,
    output logic [RK_W-1:0]             rd_data
);

    // Entries are deliberately unreset; they are only read after a complete load.
    logic [RK_W-1:0] mem [NUM_RK];

    // Write port: caller guarantees wr_idx is in range when wr_en is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - captures AES round keys and replays them forward or reverse
module round_key_store #(
    parameter int NUM_RK = aes_pkg::NUM_RK,
    parameter int RK_W   = aes_pkg::RK_W
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            ks_load,
    input  logic [3:0]      ks_round,
    input  logic [RK_W-1:0] ks_out,
    input  logic            rk_start,
    input  logic            rk_dir,
    input  logic            rk_req,
    output logic            rk_valid,
    output logic [RK_W-1:0] rk_key,
    output logic [3:0]      rk_idx,
    output logic            rk_last,
    output logic            keys_ready
);
    import aes_pkg::*;

    localparam logic [3:0]        LAST_IDX = 4'(NUM_RK - 1);
    localparam logic [NUM_RK-1:0] ONE_HOT0 = {{(NUM_RK-1){1'b0}}, 1'b1};

    rks_state_t        state;
    rks_state_t        state_nxt;
    logic              ks_load_q;
    logic [NUM_RK-1:0] bitmap;
    logic [NUM_RK-1:0] bitmap_nxt;
    logic              dir_q;
    logic              ks_rise;
    logic              load_wr;
    logic              seq_start;
    logic              seq_step;
    logic              seq_end;
    logic [3:0]        idx_nxt;
    logic              last_nxt;
    logic [RK_W-1:0]   rd_key;

    // A new producer burst restarts capture; its first key is written in the same cycle.
    assign ks_rise = ks_load & ~ks_load_q;
    assign load_wr = ks_load && (ks_round <= LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and sequencing decisions; a load rising edge overrides everything else.
    always_comb begin
        state_nxt  = state;
        seq_start  = 1'b0;
        seq_step   = 1'b0;
        seq_end    = 1'b0;
        idx_nxt    = rk_idx;
        bitmap_nxt = (ks_rise ? '0 : bitmap) | (load_wr ? (ONE_HOT0 << ks_round) : '0);
        if (ks_rise) begin
            state_nxt = LOADING;
        end else begin
            case (state)
                LOADING: begin
                    if ((&bitmap) && !ks_load) begin
                        state_nxt = READY;
                    end
                end
                READY: begin
                    if (rk_start) begin
                        state_nxt = SERVE;
                        seq_start = 1'b1;
                        idx_nxt   = rk_dir ? LAST_IDX : 4'd0;
                    end
                end
                SERVE: begin
                    if (rk_valid && rk_req) begin
                        if (rk_last) begin
                            state_nxt = READY;
                            seq_end   = 1'b1;
                        end else begin
                            seq_step = 1'b1;
                            idx_nxt  = dir_q ? (rk_idx - 4'd1) : (rk_idx + 4'd1);
                        end
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
        last_nxt = (seq_start ? rk_dir : dir_q) ? (idx_nxt == 4'd0) : (idx_nxt == LAST_IDX);
    end

    // Load tracking plus the registered delivery outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ks_load_q <= 1'b0;
            bitmap    <= '0;
            dir_q     <= 1'b0;
            rk_valid  <= 1'b0;
            rk_key    <= '0;
            rk_idx    <= 4'd0;
            rk_last   <= 1'b0;
        end else begin
            ks_load_q <= ks_load;
            bitmap    <= bitmap_nxt;
            if (seq_start) begin
                dir_q <= rk_dir;
            end
            if (ks_rise || seq_end) begin
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
            end else if (seq_start || seq_step) begin
                rk_valid <= 1'b1;
                rk_idx   <= idx_nxt;
                rk_key   <= rd_key;
                rk_last  <= last_nxt;
            end
        end
    end

    assign keys_ready = (state == READY) || (state == SERVE);

    rk_regfile #(
        .NUM_RK (NUM_RK),
        .RK_W   (RK_W)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (load_wr),
        .wr_idx  (ks_round),
        .wr_data (ks_out),
        .rd_idx  (idx_nxt),
        .rd_data (rd_key)
    );

endmodule

// File: tb/tb_round_key_store.sv
// tb/tb_round_key_store.sv - self-checking bench for round_key_store
module tb_round_key_store;

    localparam int NRK = 15;
    localparam int W   = 128;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         ks_load = 1'b0;
    logic [3:0]   ks_round = 4'd0;
    logic [W-1:0] ks_out = '0;
    logic         rk_start = 1'b0;
    logic         rk_dir = 1'b0;
    logic         rk_req = 1'b0;
    logic         rk_valid;
    logic [W-1:0] rk_key;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         keys_ready;

    int total = 0;
    int bad   = 0;

    // Reference model: key contents, which entries hold fresh keys, ready flag,
    // and the queue of indices still to be delivered in the current sequence.
    logic [W-1:0] m_key [NRK];
    bit           m_have [NRK];
    bit           m_ready;
    bit           m_prev_load;
    int           m_q[$];

    round_key_store dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .ks_load    (ks_load),
        .ks_round   (ks_round),
        .ks_out     (ks_out),
        .rk_start   (rk_start),
        .rk_dir     (rk_dir),
        .rk_req     (rk_req),
        .rk_valid   (rk_valid),
        .rk_key     (rk_key),
        .rk_idx     (rk_idx),
        .rk_last    (rk_last),
        .keys_ready (keys_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit all_have();
        for (int i = 0; i < NRK; i++) begin
            if (!m_have[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] rkey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NRK; i++) m_have[i] = 1'b0;
        m_ready     = 1'b0;
        m_prev_load = 1'b0;
        m_q.delete();
    endtask

    task automatic model_edge();
        bit rise;
        if (!n_rst) begin
            model_reset();
            return;
        end
        rise = ks_load && !m_prev_load;
        if (rise) begin
            for (int i = 0; i < NRK; i++) m_have[i] = 1'b0;
            m_ready = 1'b0;
            m_q.delete();
        end else if (!m_ready && !ks_load && all_have()) begin
            m_ready = 1'b1;
        end else if (m_ready && m_q.size() == 0 && rk_start) begin
            for (int i = 0; i < NRK; i++) m_q.push_back(rk_dir ? (NRK - 1 - i) : i);
        end else if (m_q.size() > 0 && rk_req) begin
            void'(m_q.pop_front());
        end
        if (ks_load && int'(ks_round) < NRK) begin
            m_key[ks_round]  = ks_out;
            m_have[ks_round] = 1'b1;
        end
        m_prev_load = ks_load;
    endtask

    task automatic check_outputs();
        chk("keys_ready", W'(keys_ready), W'(m_ready));
        chk("rk_valid", W'(rk_valid), W'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("rk_idx", W'(rk_idx), W'(m_q[0]));
            chk("rk_key", rk_key, m_key[m_q[0]]);
            chk("rk_last", W'(rk_last), W'(m_q.size() == 1));
        end else begin
            chk("rk_last_idle", W'(rk_last), W'(0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic load_keys(input int first, input int last, input bit rnd);
        for (int i = first; i <= last; i++) begin
            ks_load  = 1'b1;
            ks_round = 4'(i);
            ks_out   = rnd ? rkey() : {32{4'(i)}};
            tick();
        end
        ks_load  = 1'b0;
        ks_round = 4'd0;
        tick();
    endtask

    task automatic load_shuffled();
        int order[NRK];
        for (int i = 0; i < NRK; i++) order[i] = i;
        for (int i = NRK - 1; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < NRK; i++) begin
            ks_load  = 1'b1;
            ks_round = 4'(order[i]);
            ks_out   = rkey();
            tick();
            if (i == 6) begin
                ks_round = 4'd15;
                ks_out   = rkey();
                tick();
            end
        end
        ks_load  = 1'b0;
        ks_round = 4'd0;
        tick();
        tick();
    endtask

    task automatic serve(input bit dir, input int mode);
        rk_start = 1'b1;
        rk_dir   = dir;
        rk_req   = (mode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
        tick();
        rk_start = 1'b0;
        for (int n = 0; n < 80; n++) begin
            case (mode)
                0:       rk_req = 1'b1;
                1:       rk_req = (n % 2 == 0);
                default: rk_req = 1'($urandom_range(1, 0));
            endcase
            tick();
            if (m_q.size() == 0) break;
        end
        chk("seq_done_valid", W'(rk_valid), W'(0));
        rk_req = 1'b0;
    endtask

    task automatic run_to_idx(input int target);
        bit found;
        found    = 1'b0;
        rk_start = 1'b1;
        rk_dir   = 1'b0;
        rk_req   = 1'b1;
        tick();
        rk_start = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (rk_valid && rk_idx == 4'(target)) found = 1'b1;
            else tick();
        end
        chk("reach_idx", W'(found), W'(1));
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        chk("rst_key", rk_key, '0);
        chk("rst_idx", W'(rk_idx), W'(0));
        n_rst = 1'b1;
        tick();

        // rk_start before any load is ignored
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        tick();

        // patterned load, forward full-rate, reverse with stalls
        load_keys(0, 14, 1'b0);
        tick();
        chk("ready_after_load", W'(keys_ready), W'(1));
        serve(1'b0, 0);
        serve(1'b1, 1);
        serve(1'b0, 2);

        // shuffled random load with an out-of-range round, random backpressure
        load_shuffled();
        serve(1'b1, 2);
        serve(1'b0, 2);

        // abort mid-sequence at idx 5 with a coincident start request
        run_to_idx(5);
        ks_load  = 1'b1;
        ks_round = 4'd0;
        ks_out   = rkey();
        rk_start = 1'b1;
        tick();
        chk("abort_valid", W'(rk_valid), W'(0));
        ks_load  = 1'b0;
        rk_start = 1'b1;
        tick();
        tick();
        rk_start = 1'b0;
        rk_req   = 1'b0;
        tick();
        load_keys(0, 14, 1'b1);
        tick();
        serve(1'b1, 2);

        // partial load leaves the store unusable
        load_keys(0, 9, 1'b1);
        tick();
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        tick();
        chk("partial_ready", W'(keys_ready), W'(0));

        // completing a fresh load restores service
        load_keys(0, 14, 1'b1);
        tick();
        serve(1'b0, 0);

        // asynchronous reset in the middle of a sequence
        run_to_idx(7);
        n_rst = 1'b0;
        #1;
        chk("arst_valid", W'(rk_valid), W'(0));
        chk("arst_key", rk_key, '0);
        chk("arst_idx", W'(rk_idx), W'(0));
        chk("arst_last", W'(rk_last), W'(0));
        chk("arst_ready", W'(keys_ready), W'(0));
        model_reset();
        tick();
        n_rst = 1'b1;
        tick();
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        tick();
        chk("post_rst_valid", W'(rk_valid), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
